// File: rtl/proc_pkg.sv
// Shared processor definitions.
// Provides the datapath width, the instruction size in bytes, the default
// bubble encoding, the default reset PC, and a helper that word-aligns
// an address.
package proc_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Force the two low bits to zero so that fetch addresses stay word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold and clear controls.
// Priority from highest to lowest: rst, flush_i, hold_i, load.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   hold_i           keep the current contents (stall)
//   flush_i          replace the contents with a bubble
//   instr_i          instruction word to capture
//   next_instr_i     PC+4 of that instruction
//   instr_o          registered instruction
//   next_instr_o     registered PC+4
//   valid_o          high when instr_o is a real instruction
module ifid_reg
  import proc_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] next_instr_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] next_instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_q, next_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    next_d  = next_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      next_d  = '0;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      instr_d = instr_i;
      next_d  = next_instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      next_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      next_q  <= next_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o      = instr_q;
  assign next_instr_o = next_q;
  assign valid_o      = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// This module holds the PC, drives the instruction-memory address and
// produces PC+4. A taken branch redirects fetch and flushes IF/ID. A stall
// holds both the PC and IF/ID. It also counts flushes, with saturation,
// and reports word-misaligned branch targets.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   imemAddr        instruction-memory address (= pc)
//   imemData        instruction word at imemAddr (combinational read)
//   nextInstr       pc + 4, to branch computation
//   branchTaken     redirect request
//   branchAddress   redirect target
//   stall           hazard-unit hold request
//   ifidInstr       registered instruction to decode
//   ifidNextInstr   registered PC+4 of that instruction
//   ifidValid       ifidInstr is a real instruction
//   misalignErr     one-cycle pulse after a redirect to a misaligned target
//   flushCount      saturating count of flushes since reset
module fetch_stage
  import proc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  imemAddr,
  input  logic [XLEN-1:0]  imemData,
  output logic [XLEN-1:0]  nextInstr,
  input  logic             branchTaken,
  input  logic [XLEN-1:0]  branchAddress,
  input  logic             stall,
  output logic [XLEN-1:0]  ifidInstr,
  output logic [XLEN-1:0]  ifidNextInstr,
  output logic             ifidValid,
  output logic             misalignErr,
  output logic [CNT_W-1:0] flushCount
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // The addition wraps modulo 2^32, and the carry out is dropped.
  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

  always_comb begin
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    flush_cnt_d = flush_cnt_q;
    if (branchTaken) begin
      // A branch beats a stall. The wrong-path fetch is never held.
      pc_d       = align_word(branchAddress);
      misalign_d = |branchAddress[1:0];
      if (!(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk          (clk),
    .rst          (rst),
    .hold_i       (stall),
    .flush_i      (branchTaken),
    .instr_i      (imemData),
    .next_instr_i (pc_plus4),
    .instr_o      (ifidInstr),
    .next_instr_o (ifidNextInstr),
    .valid_o      (ifidValid)
  );

  assign imemAddr    = pc_q;
  assign nextInstr   = pc_plus4;
  assign misalignErr = misalign_q;
  assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage.
// Two instances run in lockstep and share the same control stimulus:
//   d0 uses the default parameters.
//   d1 uses RESET_PC = 0xFFFF_FFFC and a 4-bit flush counter, so the
//   address wrap and counter saturation can be reached quickly.
// Each instance has its own reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, bt, st;
  logic [31:0] ba, data;

  logic [31:0] a0, n0, i0, x0, a1, n1, i1, x1;
  logic        v0, m0, v1, m1;
  logic [15:0] c0;
  logic [3:0]  c1;

  int tests = 0;
  int fails = 0;

  // Per-instance model state. Index 0 is d0 and index 1 is d1.
  logic [31:0] m_pc[2], m_instr[2], m_next[2];
  logic        m_valid[2], m_mis[2];
  int          m_cnt[2];
  int          m_rpc[2];
  int          m_cmax[2];

  always #5 clk = ~clk;

  fetch_stage d0 (
    .clk(clk), .rst(rst), .imemAddr(a0), .imemData(data), .nextInstr(n0),
    .branchTaken(bt), .branchAddress(ba), .stall(st),
    .ifidInstr(i0), .ifidNextInstr(x0), .ifidValid(v0),
    .misalignErr(m0), .flushCount(c0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) d1 (
    .clk(clk), .rst(rst), .imemAddr(a1), .imemData(data), .nextInstr(n1),
    .branchTaken(bt), .branchAddress(ba), .stall(st),
    .ifidInstr(i1), .ifidNextInstr(x1), .ifidValid(v1),
    .misalignErr(m1), .flushCount(c1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the spec rules to one model instance at a clock edge.
  task automatic model_edge(input int k);
    if (rst) begin
      m_pc[k] = m_rpc[k];
      m_instr[k] = 32'h0;
      m_next[k] = 32'h0;
      m_valid[k] = 1'b0;
      m_mis[k] = 1'b0;
      m_cnt[k] = 0;
    end else if (bt) begin
      m_pc[k] = ba - (ba % 4);
      m_instr[k] = 32'h0;
      m_next[k] = 32'h0;
      m_valid[k] = 1'b0;
      m_mis[k] = (ba % 4) != 0;
      m_cnt[k] = (m_cnt[k] < m_cmax[k]) ? m_cnt[k] + 1 : m_cmax[k];
    end else begin
      m_mis[k] = 1'b0;
      if (!st) begin
        m_instr[k] = data;
        m_next[k] = m_pc[k] + 32'd4;
        m_valid[k] = 1'b1;
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    check("d0.imemAddr", a0, m_pc[0]);
    check("d0.nextInstr", n0, m_pc[0] + 32'd4);
    check("d0.ifidInstr", i0, m_instr[0]);
    check("d0.ifidNextInstr", x0, m_next[0]);
    check("d0.ifidValid", {31'b0, v0}, {31'b0, m_valid[0]});
    check("d0.misalignErr", {31'b0, m0}, {31'b0, m_mis[0]});
    check("d0.flushCount", {16'b0, c0}, m_cnt[0]);
    check("d1.imemAddr", a1, m_pc[1]);
    check("d1.nextInstr", n1, m_pc[1] + 32'd4);
    check("d1.ifidInstr", i1, m_instr[1]);
    check("d1.ifidNextInstr", x1, m_next[1]);
    check("d1.ifidValid", {31'b0, v1}, {31'b0, m_valid[1]});
    check("d1.misalignErr", {31'b0, m1}, {31'b0, m_mis[1]});
    check("d1.flushCount", {28'b0, c1}, m_cnt[1]);
  endtask

  // Drive one cycle of inputs, clock it, update the models, then compare.
  task automatic step(input logic r, input logic b, input logic [31:0] addr,
                      input logic s, input logic [31:0] d);
    rst = r; bt = b; ba = addr; st = s; data = d;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    $display("[TB] rst=%0b br=%0b ba=%h st=%0b data=%h | pc0=%h ifid0=%h/%h v=%0b cnt=%0d | pc1=%h mis1=%0b cnt1=%0d",
             r, b, addr, s, d, a0, i0, x0, v0, c0, a1, m1, c1);
    check_all();
  endtask

  initial begin
    m_rpc[0] = 32'h0;         m_rpc[1] = 32'hFFFF_FFFC;
    m_cmax[0] = 65535;        m_cmax[1] = 15;
    rst = 1'b1; bt = 1'b0; ba = '0; st = 1'b0; data = '0;
    #1;

    // Test 1: reset, then free-run.
    step(1, 0, 0, 0, 32'h0);
    check("reset.nextInstr1", n1, 32'h0);
    step(0, 0, 0, 0, 32'hAAAA0001);
    check("t1.ifidInstr", i0, 32'hAAAA0001);
    check("t1.ifidValid", {31'b0, v0}, 32'd1);
    check("t5.advance.imemAddr1", a1, 32'h0);
    step(0, 0, 0, 0, 32'hAAAA0002);
    step(0, 0, 0, 0, 32'hAAAA0003);
    check("t1.imemAddr", a0, 32'd12);
    check("t1.ifidNextInstr", x0, 32'd12);

    // Test 3: stall for 2 cycles at pc=16.
    step(0, 0, 0, 0, $urandom);
    check("t3.pc16", a0, 32'd16);
    step(0, 0, 0, 1, $urandom);
    step(0, 0, 0, 1, $urandom);
    check("t3.hold", a0, 32'd16);
    step(0, 0, 0, 0, $urandom);
    check("t3.release", a0, 32'd20);

    // Test 2: advance to pc=96, then branch to 2148.
    while (m_pc[0] != 32'd96) step(0, 0, 0, 0, $urandom);
    step(0, 1, 32'd2148, 0, $urandom);
    check("t2.target", a0, 32'd2148);
    check("t2.valid", {31'b0, v0}, 32'd0);
    check("t2.count", {16'b0, c0}, 32'd1);
    step(0, 0, 0, 0, $urandom);
    check("t2.ifidNext", x0, 32'd2152);

    // Test 4: branch plus stall. The branch wins.
    step(0, 1, 32'h40, 1, $urandom);
    check("t4.pc", a0, 32'h40);
    check("t4.flushValid", {31'b0, v0}, 32'd0);

    // Test 5: misaligned target.
    step(0, 1, 32'h102, 0, $urandom);
    check("t5.pc", a1, 32'h100);
    check("t5.mis", {31'b0, m1}, 32'd1);
    step(0, 0, 0, 0, $urandom);
    check("t5.misPulse", {31'b0, m1}, 32'd0);

    // Back-to-back branches. The last one decides the pc. Saturate d1's counter.
    for (int i = 0; i < 18; i++) step(0, 1, 32'h1000 + 32'(i) * 8, 0, $urandom);
    check("b2b.pc", a0, 32'h1000 + 32'd17 * 8);
    check("sat.cnt1", {28'b0, c1}, 32'd15);

    // Test 6: reset during stall+branch.
    step(0, 0, 0, 1, $urandom);
    step(1, 1, 32'h203, 1, $urandom);
    check("t6.pc", a0, 32'h0);
    check("t6.cnt", {16'b0, c0}, 32'd0);
    check("t6.mis", {31'b0, m0}, 32'd0);

    // Randomized run against the models.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), $urandom,
           ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
